// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : disp_scan_ctrl                                                |
// | Purpose  : scan phase, brightness and fare/distance page control for the |
// |            four-digit taximeter display. Optional macro: PAGE_ROTATE_EN. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module disp_scan_ctrl #(
   parameter int         PRESCALE      = 16,
   parameter int         ROTATE_FRAMES = 256,
   parameter logic [3:0] BRIGHT_RESET  = 4'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] fare_bcd,
   input  logic [15:0] dist_bcd,
   input  logic        bright_up,
   input  logic        bright_dn,
   input  logic        page_hold,
   input  logic        page_sel,
   output logic [5:0]  scan_phase,
   output logic [3:0]  lighttag,
   output logic [15:0] snum,
   output logic        page,
   output logic        frame_tick
);

   localparam int                  c_PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(PRESCALE - 1);

   typedef enum logic [0:0] {
      ST_FARE = 1'b0,
      ST_DIST = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [c_PCNT_W-1:0] r_pcnt;
   logic [5:0]          r_scan_phase;
   logic [3:0]          r_tgt;
   logic [3:0]          r_lighttag;
   logic [15:0]         r_snum;
   logic                r_frame_tick;
   logic                w_step;
   logic                w_boundary;

   assign w_step     = (r_pcnt == c_PCNT_MAX);
   assign w_boundary = w_step && (r_scan_phase == 6'd63);

`ifdef PAGE_ROTATE_EN
   localparam int                  c_FCNT_W   = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
   localparam logic [c_FCNT_W-1:0] c_FCNT_MAX = c_FCNT_W'(ROTATE_FRAMES - 1);

   logic [c_FCNT_W-1:0] r_fcnt;

   always_comb begin
      w_next_state = r_state;
      if (page_hold)
         w_next_state = state_t'(page_sel);
      else if (r_fcnt == c_FCNT_MAX)
         w_next_state = (r_state == ST_FARE) ? ST_DIST : ST_FARE;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_fcnt <= '0;
      else if (w_boundary) begin
         if (page_hold || (r_fcnt == c_FCNT_MAX))
            r_fcnt <= '0;
         else
            r_fcnt <= r_fcnt + 1'b1;
      end
   end
`else
   // Without rotation the operator's selection alone decides the page.
   logic w_unused_hold;
   assign w_unused_hold = page_hold;

   always_comb begin
      w_next_state = state_t'(page_sel);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt       <= '0;
         r_scan_phase <= 6'd0;
         r_tgt        <= BRIGHT_RESET;
         r_lighttag   <= BRIGHT_RESET;
         r_state      <= ST_FARE;
         r_snum       <= 16'h0000;
         r_frame_tick <= 1'b0;
      end else begin
         r_pcnt       <= w_step ? '0 : r_pcnt + 1'b1;
         r_frame_tick <= w_boundary;
         if (w_step)
            r_scan_phase <= r_scan_phase + 6'd1;

         if (bright_up && !bright_dn && (r_tgt != 4'd15))
            r_tgt <= r_tgt + 4'd1;
         else if (bright_dn && !bright_up && (r_tgt != 4'd0))
            r_tgt <= r_tgt - 4'd1;

         // Display-visible values move only here; lighttag takes the target
         // as it stood before this cycle's pulses.
         if (w_boundary) begin
            r_lighttag <= r_tgt;
            r_state    <= w_next_state;
            r_snum     <= (w_next_state == ST_DIST) ? dist_bcd : fare_bcd;
         end
      end
   end

   assign scan_phase = r_scan_phase;
   assign lighttag   = r_lighttag;
   assign snum       = r_snum;
   assign page       = r_state;
   assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_disp_scan_ctrl                                             |
// | Purpose  : directed checkpoint table for disp_scan_ctrl, PRESCALE=2,     |
// |            ROTATE_FRAMES=4 (128-cycle frames).                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_disp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fare_bcd;
   logic [15:0] dist_bcd;
   logic        bright_up;
   logic        bright_dn;
   logic        page_hold;
   logic        page_sel;
   logic [5:0]  scan_phase;
   logic [3:0]  lighttag;
   logic [15:0] snum;
   logic        page;
   logic        frame_tick;

   int checks   = 0;
   int failures = 0;

`ifdef PAGE_ROTATE_EN
   localparam bit c_ROT = 1'b1;
`else
   localparam bit c_ROT = 1'b0;
`endif

   typedef struct {
      int          k;
      logic [5:0]  ph;
      logic [3:0]  lt;
      logic [15:0] sn;
      logic        pg;
      logic        ft;
   } chk_t;

   chk_t tbl[$];

   disp_scan_ctrl #(
      .PRESCALE      (2),
      .ROTATE_FRAMES (4),
      .BRIGHT_RESET  (4'd15)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .fare_bcd   (fare_bcd),
      .dist_bcd   (dist_bcd),
      .bright_up  (bright_up),
      .bright_dn  (bright_dn),
      .page_hold  (page_hold),
      .page_sel   (page_sel),
      .scan_phase (scan_phase),
      .lighttag   (lighttag),
      .snum       (snum),
      .page       (page),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic void add(int k, logic [5:0] ph, logic [3:0] lt,
                               logic [15:0] sn, logic pg, logic ft);
      chk_t c;
      c.k = k; c.ph = ph; c.lt = lt; c.sn = sn; c.pg = pg; c.ft = ft;
      tbl.push_back(c);
   endfunction

   task automatic cmp(string name, int k, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at k=%0d actual=%h required=%h", name, k, act, req);
      end
   endtask

   // Inputs for the edge numbered k (k counts edges after the initial reset edge).
   task automatic stim(int k);
      rst       = (k == 3660);
      bright_up = 1'b0;
      bright_dn = 1'b0;
      if (k == 1050) fare_bcd = 16'h9999;
      if (k == 1160 || k == 1162 || k == 1164) bright_dn = 1'b1;
      if (k == 1300) begin bright_up = 1'b1; bright_dn = 1'b1; end
      if (k == 1408) bright_up = 1'b1;
      if (k >= 1540 && k <= 1578 && (k % 2 == 0)) bright_dn = 1'b1;
      if (k == 2100) begin page_hold = 1'b1; page_sel = 1'b1; end
      if (k == 3100) page_hold = 1'b0;
      if (k >= 3600 && k <= 3616 && (k % 2 == 0)) bright_up = 1'b1;
      if (k == 3600) page_sel = 1'b0;
      // Reset must win over a simultaneous brightness pulse.
      if (k == 3660) bright_dn = 1'b1;
   endtask

   initial begin
      int idx = 0;

      //   k     phase lt     snum                   page          ft
      add(1,    6'd0,  4'd15, 16'h0000,              1'b0,         1'b0);
      add(2,    6'd1,  4'd15, 16'h0000,              1'b0,         1'b0);
      add(3,    6'd1,  4'd15, 16'h0000,              1'b0,         1'b0);
      add(127,  6'd63, 4'd15, 16'h0000,              1'b0,         1'b0);
      add(128,  6'd0,  4'd15, 16'h1234,              1'b0,         1'b1);
      add(129,  6'd0,  4'd15, 16'h1234,              1'b0,         1'b0);
      add(384,  6'd0,  4'd15, 16'h1234,              1'b0,         1'b1);
      add(512,  6'd0,  4'd15, c_ROT ? 16'h0567 : 16'h1234, c_ROT, 1'b1);
      add(513,  6'd0,  4'd15, c_ROT ? 16'h0567 : 16'h1234, c_ROT, 1'b0);
      add(1024, 6'd0,  4'd15, 16'h1234,              1'b0,         1'b1);
      add(1151, 6'd63, 4'd15, 16'h1234,              1'b0,         1'b0);
      add(1152, 6'd0,  4'd15, 16'h9999,              1'b0,         1'b1);
      add(1279, 6'd63, 4'd15, 16'h9999,              1'b0,         1'b0);
      add(1280, 6'd0,  4'd12, 16'h9999,              1'b0,         1'b1);
      add(1408, 6'd0,  4'd12, 16'h9999,              1'b0,         1'b1);
      add(1536, 6'd0,  4'd13, c_ROT ? 16'h0567 : 16'h9999, c_ROT, 1'b1);
      add(1664, 6'd0,  4'd0,  c_ROT ? 16'h0567 : 16'h9999, c_ROT, 1'b1);
      add(2048, 6'd0,  4'd0,  16'h9999,              1'b0,         1'b1);
      add(2176, 6'd0,  4'd0,  16'h0567,              1'b1,         1'b1);
      add(2688, 6'd0,  4'd0,  16'h0567,              1'b1,         1'b1);
      add(3072, 6'd0,  4'd0,  16'h0567,              1'b1,         1'b1);
      add(3456, 6'd0,  4'd0,  16'h0567,              1'b1,         1'b1);
      add(3584, 6'd0,  4'd0,  c_ROT ? 16'h9999 : 16'h0567, !c_ROT, 1'b1);
      add(3659, 6'd37, 4'd0,  c_ROT ? 16'h9999 : 16'h0567, !c_ROT, 1'b0);
      add(3660, 6'd0,  4'd15, 16'h0000,              1'b0,         1'b0);
      add(3787, 6'd63, 4'd15, 16'h0000,              1'b0,         1'b0);
      add(3788, 6'd0,  4'd15, 16'h9999,              1'b0,         1'b1);

      rst       = 1'b1;
      fare_bcd  = 16'h1234;
      dist_bcd  = 16'h0567;
      bright_up = 1'b0;
      bright_dn = 1'b0;
      page_hold = 1'b0;
      page_sel  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("reset_phase", 0, 16'(scan_phase), 16'd0);
      cmp("reset_light", 0, 16'(lighttag),   16'd15);
      cmp("reset_snum",  0, snum,            16'h0000);

      for (int k = 1; k <= 3800; k++) begin
         stim(k);
         @(posedge clk);
         #1;
         if (idx < tbl.size() && tbl[idx].k == k) begin
            cmp("scan_phase", k, 16'(scan_phase), 16'(tbl[idx].ph));
            cmp("lighttag",   k, 16'(lighttag),   16'(tbl[idx].lt));
            cmp("snum",       k, snum,            tbl[idx].sn);
            cmp("page",       k, 16'(page),       16'(tbl[idx].pg));
            cmp("frame_tick", k, 16'(frame_tick), 16'(tbl[idx].ft));
            idx++;
         end
      end
      cmp("all_checkpoints_visited", 3800, 16'(idx), 16'(tbl.size()));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
